// File: rtl/bus_sram_slave_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_sram_slave_pkg : bus transaction types and lane-mask helper
// Revision 1.0
// ---------------------------------------------------------------------------
package bus_sram_slave_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        RSVD = 2'd3
    } tsize_e;

    // Byte-enable pattern for a lane-0 access of the given size.
    function automatic logic [3:0] tsize_mask(input tsize_e sz);
        case (sz)
            BYTE:    tsize_mask = 4'b0001;
            HALF:    tsize_mask = 4'b0011;
            WORD:    tsize_mask = 4'b1111;
            default: tsize_mask = 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_sram_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_sram_slave_if : master bus between an initiator and a responder
// Revision 1.0
// ---------------------------------------------------------------------------
interface bus_sram_slave_if;
    import bus_sram_slave_pkg::*;

    logic        breq;
    logic        bstart;
    ttype_e      ttype;
    tsize_e      tsize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;
    logic        err;

    modport master (
        output breq, bstart, ttype, tsize, addr, wdata,
        input  rdata, bdone, err
    );

    modport slave (
        input  breq, bstart, ttype, tsize, addr, wdata,
        output rdata, bdone, err
    );

endinterface
`default_nettype wire

// File: rtl/bus_sram_slave_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_bank : DEPTH x 32 SRAM, byte-enabled synchronous write, sync read
// Revision 1.0
// ---------------------------------------------------------------------------
module sram_bank #(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          i_en,
    input  wire logic [3:0]    i_be,
    input  wire logic [AW-1:0] i_idx,
    input  wire logic [31:0]   i_wdata,
    output logic      [31:0]   o_rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Read-first: a write cycle returns the old word, which the caller ignores.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) mem_q[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            rdata_q <= mem_q[i_idx];
        end
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/bus_sram_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_sram_slave : word SRAM responder with lane steering and wait states
// Revision 1.0
// ---------------------------------------------------------------------------
module bus_sram_slave
    import bus_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bus_sram_slave_if.slave    bus
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [32:0] C_SIZE = 33'(4 * DEPTH);
    localparam logic [3:0]  C_WAIT = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    tsize_e      size_q, size_d;
    logic        read_q, read_d;
    logic        errp_q, errp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bdone_q, bdone_d;
    logic        err_q, err_d;

    logic [32:0] w_diff;
    logic        w_oor;
    logic        w_mis;
    logic        w_err;
    logic        w_enter;
    logic [3:0]  w_be;
    logic [31:0] w_bank_rdata;
    logic [31:0] w_shifted;
    logic [3:0]  w_lmask;
    logic [31:0] w_dmask;
    logic        w_unused;

    // A negative offset wraps to a huge 33-bit value, so one compare covers both ends.
    assign w_diff = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
    assign w_oor  = (w_diff >= C_SIZE);

    always_comb begin
        case (bus.tsize)
            BYTE:    w_mis = 1'b0;
            HALF:    w_mis = bus.addr[0];
            WORD:    w_mis = (bus.addr[1:0] != 2'b00);
            default: w_mis = 1'b1;
        endcase
    end

    assign w_err   = w_oor | w_mis;
    assign w_enter = ((state_q == S_IDLE) && bus.breq && bus.bstart && (C_WAIT == 4'd0))
                   || ((state_q == S_WAIT) && (cnt_q == 4'd1));
    assign w_be    = (bus.ttype == WRITE) ? (tsize_mask(bus.tsize) << bus.addr[1:0]) : 4'b0000;

    sram_bank #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk     (clk),
        .i_en    (w_enter && !w_err),
        .i_be    (w_be),
        .i_idx   (w_diff[AW+1:2]),
        .i_wdata (bus.wdata << {bus.addr[1:0], 3'b000}),
        .o_rdata (w_bank_rdata)
    );

    assign w_shifted = w_bank_rdata >> {lane_q, 3'b000};
    assign w_lmask   = tsize_mask(size_q);
    assign w_dmask   = {{8{w_lmask[3]}}, {8{w_lmask[2]}}, {8{w_lmask[1]}}, {8{w_lmask[0]}}};
    assign w_unused  = ^{w_diff[32:AW+2], w_diff[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        size_d  = size_q;
        read_d  = read_q;
        errp_d  = errp_q;
        rdata_d = rdata_q;
        bdone_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.breq && bus.bstart) begin
                    cnt_d   = C_WAIT;
                    state_d = (C_WAIT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                bdone_d = 1'b1;
                err_d   = errp_q;
                if (read_q) rdata_d = errp_q ? 32'd0 : (w_shifted & w_dmask);
                state_d = S_GAP;
            end
            default: state_d = S_IDLE;
        endcase

        // Decode is captured on the same edge that issues the bank access.
        if (w_enter) begin
            lane_d = bus.addr[1:0];
            size_d = bus.tsize;
            read_d = (bus.ttype == READ);
            errp_d = w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            lane_q  <= 2'd0;
            size_q  <= BYTE;
            read_q  <= 1'b0;
            errp_q  <= 1'b0;
            rdata_q <= 32'd0;
            bdone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            read_q  <= read_d;
            errp_q  <= errp_d;
            rdata_q <= rdata_d;
            bdone_q <= bdone_d;
            err_q   <= err_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.bdone = bdone_q;
    assign bus.err   = err_q;

endmodule
`default_nettype wire
